multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Parametrised multicycle successor to the TinyChip single-cycle controller: FSM sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
//  Holds PC and a 4-entry register file, and drives a synchronous instruction memory and a req/ready data memory.
//  Implements taken branches, register jump and halt. Top-level core of the TinyChip CPU.
// PARAMETERS
//  DATA_W    8      datapath / register width (>=4)
//  PC_W      8      program counter / imem address width
//  RESET_PC  0      PC value loaded on reset
//  DM_TMO    15     dmem wait-cycle limit (used only with MC_DMEM_TIMEOUT_EN)
// PORTS
//  clk          in   1       clock, all state on posedge
//  reset        in   1       asynchronous, active-low reset
//  imem_addr    out  PC_W    fetch address, = PC
//  imem_rdata   in   9       instruction, valid 1 cycle after imem_addr
//  dmem_req     out  1       data access request
//  dmem_we      out  1       1=store, 0=load; valid while dmem_req
//  dmem_addr    out  DATA_W  data address
//  dmem_wdata   out  DATA_W  store data
//  dmem_rdata   in   DATA_W  load data, valid in the dmem_ready cycle
//  dmem_ready   in   1       access complete
//  output_data  out  DATA_W  last value written to a register, or last store data
//  halted       out  1       core is in HALT or FAULT
//  fault        out  1       dmem timeout (only with the macro)
// BEHAVIOUR
//  Encoding: [8]=bt, [7:5]=op, [4:3]=rd, [2:1]=rs, [0]=fn. imm = {rs,fn}: zext for ALU ops, sext for branches.
//  bt=1: 000 addi, 001 andi, 010 beq, 011 bne, 100 lw, 101 sw, 110 srl, 111 slti.
//    addi/andi/srl/slti: R[rd] <= R[rd] op imm. srl is logical. slti is unsigned (1/0).
//    beq/bne: if R[rd] ==/!= 0 then PC <= PC+sext(imm), else PC+1.
//    lw: R[rd] <= M[R[rs]]. sw: M[R[rs]] <= R[rd].
//  bt=0: R[rd] <= R[rd] op R[rs] for 000 add, 001 and, 010 or, 011 xor, 100 sub, 101 sltu, 110 sll.
//    sll uses shamt = R[rs]; shamt >= DATA_W yields 0.
//    111: fn=1 jr, PC <= R[rs] (zext or truncate to PC_W); fn=0 halt.
//  States:
//    FETCH: drive PC.
//    DECODE: latch IR, read operands.
//    EXEC: compute; branch, jr and halt resolve here.
//    MEM: lw/sw only.
//    WB: register write, PC+1.
//  CPI: ALU ops 4; branch/jr 3; lw/sw 5 + ready wait.
//  Halt: enters HALT; halted=1 until reset, with no further fetches.
//  Arithmetic: results truncated to DATA_W. PC wraps mod 2^PC_W, including on branch offsets.
//  dmem handshake:
//    dmem_req rises on MEM entry; addr/we/wdata stay stable while req=1.
//    dmem_ready sampled each MEM cycle; on ready=1, rdata captured and req drops next cycle.
//    ready=1 outside MEM is ignored. ready=1 in the first MEM cycle is legal (MEM lasts 1 cycle).
//  output_data updates in WB (register value) or at sw completion (store data); otherwise holds.
//  Reset (any time, incl. mid-MEM) clears asynchronously:
//    state=FETCH, PC=RESET_PC, regs=0, output_data=0;
//    dmem_req/dmem_we/halted/fault=0.
//  Reset release: first fetch of RESET_PC on the first posedge.
// CONFIGURATION
//  `MC_DMEM_TIMEOUT_EN defined: a counter runs in MEM.
//    If DM_TMO cycles pass with no ready: drop req, enter FAULT (halted=1, fault=1) until reset.
//    No register or output update for the aborted access.
//  Undefined: MEM waits indefinitely; fault tied 0; counter absent.
// STRUCTURE
//  Package mc_pkg holds:
//    state_t enum (FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT);
//    opcode localparams for I/R forms;
//    field-slice functions for the instruction encoding.
//  One sub-module: mc_alu, combinational, parameter DATA_W, inputs (a, b, op, bt), output result.
//  FSM, PC, IR and register file stay in multicycle_controller.
// TESTING
//  1. addi R0,5; addi R1,3; add R0,R1 -> R0=8, output_data=8, 4 cycles/instr.
//  2. R2=0; beq R2 with imm=-2 -> PC=PC-2 (wraps at 0 to 2^PC_W-2); R2=1 -> PC+1.
//  3. sw R1=0xA5 to addr R3=0x10, ready after 3 waits -> req high 4 cycles, stable addr/data;
//     lw back -> R0=0xA5.
//  4. DATA_W=16 build: sll by 20 -> 0; addi 7 to 0xFFFF -> 0x0006; jr R=0x1234 with PC_W=8 -> PC=0x34.
//  5. halt -> halted=1 and imem_addr frozen for 20 cycles.
//     Reset asserted mid-MEM -> dmem_req=0 immediately; PC=RESET_PC after release.
//  6. With MC_DMEM_TIMEOUT_EN, ready never asserted -> fault=1 after DM_TMO cycles, rd unchanged.
//     Without the macro, still waiting after 100 cycles.

Source files
------------

// File: rtl/mc_pkg.sv
// Package for the TinyChip multicycle controller.
// Holds the FSM state type, the I-form and R-form opcode values, and the
// field-slice helpers for the 9-bit instruction word
// [8]=bt, [7:5]=op, [4:3]=rd, [2:1]=rs, [0]=fn, imm={rs,fn}.
package mc_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT,
    FAULT
  } state_t;

  // bt=1 (immediate / branch / memory) opcodes
  localparam logic [2:0] OP_ADDI = 3'b000;
  localparam logic [2:0] OP_ANDI = 3'b001;
  localparam logic [2:0] OP_BEQ  = 3'b010;
  localparam logic [2:0] OP_BNE  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_SRL  = 3'b110;
  localparam logic [2:0] OP_SLTI = 3'b111;

  // bt=0 (register-register) opcodes
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b110;
  localparam logic [2:0] OP_SYS  = 3'b111;  // fn=1 jr, fn=0 halt

  function automatic logic f_bt(input logic [8:0] ins);
    return ins[8];
  endfunction

  function automatic logic [2:0] f_op(input logic [8:0] ins);
    return ins[7:5];
  endfunction

  function automatic logic [1:0] f_rd(input logic [8:0] ins);
    return ins[4:3];
  endfunction

  function automatic logic [1:0] f_rs(input logic [8:0] ins);
    return ins[2:1];
  endfunction

  function automatic logic f_fn(input logic [8:0] ins);
    return ins[0];
  endfunction

  function automatic logic [2:0] f_imm(input logic [8:0] ins);
    return ins[2:0];
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the multicycle controller.
// Ports: a (rd operand), b (rs operand or zero-extended immediate),
//        op (opcode field), bt (instruction form), result (DATA_W wide).
// Comparisons are unsigned; srl is logical; sll by >= DATA_W yields 0.
module mc_alu
  import mc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  input  logic              bt,
  output logic [DATA_W-1:0] result
);

  localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

  always_comb begin
    result = a;
    if (bt) begin
      case (op)
        OP_ADDI: result = a + b;
        OP_ANDI: result = a & b;
        OP_SRL:  result = a >> b;
        OP_SLTI: result = DATA_W'(a < b);
        default: result = a;
      endcase
    end else begin
      case (op)
        OP_ADD:  result = a + b;
        OP_AND:  result = a & b;
        OP_OR:   result = a | b;
        OP_XOR:  result = a ^ b;
        OP_SUB:  result = a - b;
        OP_SLTU: result = DATA_W'(a < b);
        OP_SLL:  result = (b >= SHIFT_LIM) ? '0 : (a << b);
        default: result = a;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// TinyChip multicycle core: FETCH/DECODE/EXEC/MEM/WB sequencer with PC,
// instruction register and a 4-entry register file.
// Ports: clk, reset (async, active-low), imem_addr/imem_rdata (synchronous
//        instruction memory, data one cycle after address), dmem_req/we/
//        addr/wdata/rdata/ready (req/ready data memory), output_data (last
//        register write or store data), halted, fault.
// Optional feature: define MC_DMEM_TIMEOUT_EN to abort a data access after
// DM_TMO MEM cycles without ready and park in FAULT.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0,
  parameter int DM_TMO   = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [8:0]        imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic [DATA_W-1:0] output_data,
  output logic              halted,
  output logic              fault
);

  state_t              state;
  logic [PC_W-1:0]     pc;
  logic [8:0]          ir;
  logic [DATA_W-1:0]   regs [4];
  logic [DATA_W-1:0]   opa;      // R[rd] captured in DECODE
  logic [DATA_W-1:0]   opb;      // R[rs] captured in DECODE
  logic [DATA_W-1:0]   res;      // ALU result or load data awaiting WB
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_res;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     pc_br;
  logic                br_taken;
  logic                is_br;
  logic                is_mem;
  logic                is_sys;
  logic                is_sw;

`ifdef MC_DMEM_TIMEOUT_EN
  localparam int TMO_W = (DM_TMO > 1) ? $clog2(DM_TMO) : 1;
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign fault = 1'b0;
`endif

  assign imem_addr = pc;
  assign pc_inc    = pc + PC_W'(1);
  // Offset is sign-extended to PC_W so the add wraps modulo 2^PC_W.
  assign pc_br     = pc + PC_W'($signed(f_imm(ir)));
  assign br_taken  = (opa == '0) ^ (f_op(ir) == OP_BNE);
  assign alu_b     = f_bt(ir) ? DATA_W'(f_imm(ir)) : opb;

  assign is_br  = f_bt(ir) && ((f_op(ir) == OP_BEQ) || (f_op(ir) == OP_BNE));
  assign is_mem = f_bt(ir) && ((f_op(ir) == OP_LW) || (f_op(ir) == OP_SW));
  assign is_sys = !f_bt(ir) && (f_op(ir) == OP_SYS);
  assign is_sw  = f_bt(ir) && (f_op(ir) == OP_SW);

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (opa),
    .b      (alu_b),
    .op     (f_op(ir)),
    .bt     (f_bt(ir)),
    .result (alu_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= PC_W'(RESET_PC);
      ir          <= '0;
      opa         <= '0;
      opb         <= '0;
      res         <= '0;
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      output_data <= '0;
      halted      <= 1'b0;
`ifdef MC_DMEM_TIMEOUT_EN
      fault       <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        FETCH: state <= DECODE;

        // imem_rdata is valid now; operands are read straight from it.
        DECODE: begin
          ir    <= imem_rdata;
          opa   <= regs[f_rd(imem_rdata)];
          opb   <= regs[f_rs(imem_rdata)];
          state <= EXEC;
        end

        EXEC: begin
          if (is_br) begin
            pc    <= br_taken ? pc_br : pc_inc;
            state <= FETCH;
          end else if (is_mem) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_sw;
            dmem_addr  <= opb;
            dmem_wdata <= opa;
            state      <= MEM;
`ifdef MC_DMEM_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
          end else if (is_sys) begin
            if (f_fn(ir)) begin
              pc    <= PC_W'(opb);
              state <= FETCH;
            end else begin
              halted <= 1'b1;
              state  <= HALT;
            end
          end else begin
            res   <= alu_res;
            state <= WB;
          end
        end

        MEM: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            if (dmem_we) output_data <= dmem_wdata;
            else         res         <= dmem_rdata;
            state <= WB;
          end
`ifdef MC_DMEM_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(DM_TMO - 1)) begin
            dmem_req <= 1'b0;
            halted   <= 1'b1;
            fault    <= 1'b1;
            state    <= FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end

        WB: begin
          if (!is_sw) begin
            regs[f_rd(ir)] <= res;
            output_data    <= res;
          end
          pc    <= pc_inc;
          state <= FETCH;
        end

        HALT:    state <= HALT;
        FAULT:   state <= FAULT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: an 8-bit core runs branch/ALU/memory/halt programs and
// a 16-bit core runs wide-datapath and jr checks. Expected output_data
// events (value + cycle) and data-memory transactions are queued up front;
// monitors pop and compare whenever the DUTs present them.
module tb_multicycle_controller;
  import mc_pkg::*;

  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, rst16;
  logic [7:0]  ia8, da8, dw8, dr8, out8;
  logic [8:0]  ir8;
  logic        req8, we8, rdy8, h8, f8;
  logic [7:0]  ia16;
  logic [8:0]  ir16;
  logic [15:0] da16, dw16, dr16, out16;
  logic        req16, we16, rdy16, h16, f16;

  int tests = 0;
  int fails = 0;
  int cyc8  = 0;
  int cyc16 = 0;
  logic dm_ignore;

  logic [8:0] imem8 [256];
  logic [8:0] imem16 [256];
  logic [7:0] dmem [256];

  typedef struct { logic [15:0] val; int cyc; } ev_t;
  typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; int w; } dm_t;
  ev_t q8[$];
  ev_t q16[$];
  dm_t dq[$];

  multicycle_controller #(.DM_TMO(TMO)) dut (
    .clk(clk), .reset(rst8), .imem_addr(ia8), .imem_rdata(ir8),
    .dmem_req(req8), .dmem_we(we8), .dmem_addr(da8), .dmem_wdata(dw8),
    .dmem_rdata(dr8), .dmem_ready(rdy8), .output_data(out8),
    .halted(h8), .fault(f8)
  );

  multicycle_controller #(.DATA_W(16), .PC_W(8)) dut16 (
    .clk(clk), .reset(rst16), .imem_addr(ia16), .imem_rdata(ir16),
    .dmem_req(req16), .dmem_we(we16), .dmem_addr(da16), .dmem_wdata(dw16),
    .dmem_rdata(dr16), .dmem_ready(rdy16), .output_data(out16),
    .halted(h16), .fault(f16)
  );

  always @(posedge clk) ir8  <= imem8[ia8];
  always @(posedge clk) ir16 <= imem16[ia16];

  always @(posedge clk or negedge rst8)  if (!rst8)  cyc8  <= 0; else cyc8  <= cyc8 + 1;
  always @(posedge clk or negedge rst16) if (!rst16) cyc16 <= 0; else cyc16 <= cyc16 + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] fi(input logic [2:0] op, input int rd, input logic [2:0] imm);
    logic [1:0] r;
    r = rd[1:0];
    return {1'b1, op, r, imm};
  endfunction

  function automatic logic [8:0] fr(input logic [2:0] op, input int rd, input int rs, input logic fn);
    logic [1:0] a, b;
    a = rd[1:0];
    b = rs[1:0];
    return {1'b0, op, a, b, fn};
  endfunction

  task automatic e8(input logic [15:0] v, input int c);
    ev_t e;
    e.val = v; e.cyc = c;
    q8.push_back(e);
  endtask

  task automatic e16(input logic [15:0] v, input int c);
    ev_t e;
    e.val = v; e.cyc = c;
    q16.push_back(e);
  endtask

  task automatic wait8(input int n);
    while (cyc8 < n) @(negedge clk);
  endtask

  // output_data monitors: every change outside reset is one scoreboard event
  initial begin : mon8
    logic [7:0] prev;
    ev_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst8) prev = '0;
      else if (out8 !== prev) begin
        prev = out8;
        if (q8.size() == 0) begin
          tests++; fails++;
          $display("FAIL out8 unexpected: got %h at cycle %0d expected no event", out8, cyc8);
        end else begin
          e = q8.pop_front();
          chk("out8 value", 32'(out8), 32'(e.val));
          chk("out8 cycle", 32'(cyc8), 32'(e.cyc));
        end
      end
    end
  end

  initial begin : mon16
    logic [15:0] prev;
    ev_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst16) prev = '0;
      else if (out16 !== prev) begin
        prev = out16;
        if (q16.size() == 0) begin
          tests++; fails++;
          $display("FAIL out16 unexpected: got %h at cycle %0d expected no event", out16, cyc16);
        end else begin
          e = q16.pop_front();
          chk("out16 value", 32'(out16), 32'(e.val));
          chk("out16 cycle", 32'(cyc16), 32'(e.cyc));
        end
      end
    end
  end

  // Data memory model: pops the expected transaction at request, holds
  // ready low for the scheduled wait cycles, then completes.
  initial begin : dm_model
    dm_t d;
    rdy8 = 1'b0;
    dr8  = '0;
    forever begin
      @(negedge clk);
      if (rst8 && req8 && !dm_ignore) begin
        if (dq.size() == 0) begin
          tests++; fails++;
          $display("FAIL dmem unexpected request: got addr %h expected none", da8);
        end else begin
          d = dq.pop_front();
          chk("dmem we", 32'(we8), 32'(d.we));
          chk("dmem addr", 32'(da8), 32'(d.addr));
          if (d.we) chk("dmem wdata", 32'(dw8), 32'(d.wdata));
          for (int k = 0; k < d.w; k++) begin
            @(negedge clk);
            chk("dmem req held", 32'(req8), 32'd1);
            chk("dmem addr stable", 32'(da8), 32'(d.addr));
            chk("dmem wdata stable", 32'(dw8), 32'(d.wdata));
          end
          rdy8 = 1'b1;
          dr8  = dmem[da8];
          if (we8) dmem[da8] = dw8;
          @(negedge clk);
          rdy8 = 1'b0;
          dr8  = '0;
          chk("dmem req drop", 32'(req8), 32'd0);
        end
      end
    end
  end

  initial begin : main
    dm_t d;
    rst8 = 1'b0; rst16 = 1'b0; rdy16 = 1'b0; dr16 = '0; dm_ignore = 1'b0;
    for (int i = 0; i < 256; i++) begin
      imem8[i]  = fr(OP_SYS, 0, 0, 1'b0);
      imem16[i] = fr(OP_SYS, 0, 0, 1'b0);
    end

    // 8-bit program: branch wrap, ALU, sw/lw, more ALU, bne, halt
    imem8[0]   = fi(OP_BEQ, 2, 3'b110);
    imem8[254] = fi(OP_ADDI, 2, 3'd1);
    imem8[255] = fi(OP_BEQ, 2, 3'b110);
    imem8[1]   = fi(OP_ADDI, 0, 3'd5);
    imem8[2]   = fi(OP_ADDI, 1, 3'd3);
    imem8[3]   = fr(OP_ADD, 0, 1, 1'b0);
    imem8[4]   = fi(OP_ADDI, 2, 3'd4);
    imem8[5]   = fi(OP_ANDI, 1, 3'd0);
    imem8[6]   = fi(OP_ADDI, 1, 3'd5);
    imem8[7]   = fr(OP_SLL, 1, 2, 1'b0);
    imem8[8]   = fi(OP_ADDI, 1, 3'd5);
    imem8[9]   = fi(OP_ADDI, 3, 3'd4);
    imem8[10]  = fr(OP_ADD, 3, 3, 1'b0);
    imem8[11]  = fr(OP_ADD, 3, 3, 1'b0);
    imem8[12]  = fi(OP_SW, 1, 3'b110);
    imem8[13]  = fi(OP_ANDI, 0, 3'd0);
    imem8[14]  = fi(OP_LW, 0, 3'b110);
    imem8[15]  = fi(OP_SRL, 0, 3'd3);
    imem8[16]  = fi(OP_SLTI, 0, 3'd5);
    imem8[17]  = fi(OP_SLTI, 0, 3'd5);
    imem8[18]  = fr(OP_XOR, 0, 1, 1'b0);
    imem8[19]  = fr(OP_OR, 0, 3, 1'b0);
    imem8[20]  = fr(OP_SUB, 3, 1, 1'b0);
    imem8[21]  = fr(OP_SLTU, 3, 1, 1'b0);
    imem8[22]  = fr(OP_AND, 1, 0, 1'b0);
    imem8[23]  = fi(OP_BNE, 3, 3'b010);
    imem8[24]  = fi(OP_ADDI, 0, 3'd1);
    imem8[25]  = fi(OP_ADDI, 2, 3'd7);
    imem8[26]  = fr(OP_SYS, 0, 0, 1'b0);

    e8(8'h01, 7);   e8(8'h05, 17);  e8(8'h03, 21);  e8(8'h08, 25);
    e8(8'h05, 29);  e8(8'h00, 33);  e8(8'h05, 37);  e8(8'hA0, 41);
    e8(8'hA5, 45);  e8(8'h04, 49);  e8(8'h08, 53);  e8(8'h10, 57);
    e8(8'hA5, 64);  e8(8'h00, 69);  e8(8'hA5, 74);  e8(8'h14, 78);
    e8(8'h00, 82);  e8(8'h01, 86);  e8(8'hA4, 90);  e8(8'hB4, 94);
    e8(8'h6B, 98);  e8(8'h01, 102); e8(8'hA4, 106); e8(8'h0C, 113);

    d.we = 1'b1; d.addr = 8'h10; d.wdata = 8'hA5; d.w = 3; dq.push_back(d);
    d.we = 1'b0; d.addr = 8'h10; d.wdata = 8'hA5; d.w = 0; dq.push_back(d);

    // 16-bit program: sub wrap, addi wrap, sll >= width, build 0x1234, jr
    imem16[0]  = fi(OP_ADDI, 0, 3'd1);
    imem16[1]  = fr(OP_SUB, 1, 0, 1'b0);
    imem16[2]  = fi(OP_ADDI, 1, 3'd7);
    imem16[3]  = fi(OP_ADDI, 2, 3'd5);
    imem16[4]  = fr(OP_ADD, 2, 2, 1'b0);
    imem16[5]  = fr(OP_ADD, 2, 2, 1'b0);
    imem16[6]  = fi(OP_ADDI, 3, 3'd3);
    imem16[7]  = fr(OP_SLL, 3, 2, 1'b0);
    imem16[8]  = fi(OP_ANDI, 2, 3'd4);
    imem16[9]  = fi(OP_ADDI, 3, 3'd1);
    imem16[10] = fr(OP_SLL, 3, 2, 1'b0);
    imem16[11] = fi(OP_ADDI, 3, 3'd2);
    imem16[12] = fr(OP_SLL, 3, 2, 1'b0);
    imem16[13] = fi(OP_ADDI, 3, 3'd3);
    imem16[14] = fr(OP_SLL, 3, 2, 1'b0);
    imem16[15] = fi(OP_ADDI, 3, 3'd4);
    imem16[16] = fr(OP_SYS, 0, 3, 1'b1);
    imem16[8'h34] = fi(OP_ADDI, 0, 3'd2);
    imem16[8'h35] = fr(OP_SYS, 0, 0, 1'b0);

    e16(16'h0001, 4);  e16(16'hFFFF, 8);  e16(16'h0006, 12); e16(16'h0005, 16);
    e16(16'h000A, 20); e16(16'h0014, 24); e16(16'h0003, 28); e16(16'h0000, 32);
    e16(16'h0004, 36); e16(16'h0001, 40); e16(16'h0010, 44); e16(16'h0012, 48);
    e16(16'h0120, 52); e16(16'h0123, 56); e16(16'h1230, 60); e16(16'h1234, 64);
    e16(16'h0003, 71);

    repeat (3) @(negedge clk);
    #1;
    chk("reset imem_addr", 32'(ia8), 32'd0);
    chk("reset dmem_req", 32'(req8), 32'd0);
    chk("reset dmem_we", 32'(we8), 32'd0);
    chk("reset halted", 32'(h8), 32'd0);
    chk("reset fault", 32'(f8), 32'd0);
    chk("reset output_data", 32'(out8), 32'd0);
    chk("reset imem_addr16", 32'(ia16), 32'd0);
    @(negedge clk);
    rst8 = 1'b1; rst16 = 1'b1;

    wait8(73);
    chk("halted16 before halt", 32'(h16), 32'd0);
    wait8(74);
    chk("halted16 after halt", 32'(h16), 32'd1);
    chk("imem_addr16 at halt", 32'(ia16), 32'h35);
    wait8(115);
    chk("halted before halt", 32'(h8), 32'd0);
    wait8(116);
    chk("halted after halt", 32'(h8), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("imem_addr frozen", 32'(ia8), 32'd26);
      chk("imem_addr16 frozen", 32'(ia16), 32'h35);
      chk("halted held", 32'(h8), 32'd1);
    end
    chk("scoreboard8 drained", 32'(q8.size()), 32'd0);
    chk("scoreboard16 drained", 32'(q16.size()), 32'd0);
    chk("dmem queue drained", 32'(dq.size()), 32'd0);

    // Reset mid-MEM with a never-completing load, then rerun to wait/timeout
    rst8 = 1'b0;
    dm_ignore = 1'b1;
    for (int i = 0; i < 256; i++) imem8[i] = fr(OP_SYS, 0, 0, 1'b0);
    imem8[0] = fi(OP_ADDI, 0, 3'd6);
    imem8[1] = fi(OP_LW, 0, 3'b010);
    repeat (2) @(negedge clk);
    e8(8'h06, 4);
    rst8 = 1'b1;
    wait8(12);
    chk("load pending req", 32'(req8), 32'd1);
    #2 rst8 = 1'b0;
    #1;
    chk("async reset dmem_req", 32'(req8), 32'd0);
    chk("async reset imem_addr", 32'(ia8), 32'd0);
    chk("async reset output_data", 32'(out8), 32'd0);
    chk("async reset halted", 32'(h8), 32'd0);
    repeat (2) @(negedge clk);
    e8(8'h06, 4);
    rst8 = 1'b1;
`ifdef MC_DMEM_TIMEOUT_EN
    wait8(7 + TMO - 1);
    chk("fault before limit", 32'(f8), 32'd0);
    wait8(7 + TMO);
    chk("fault at limit", 32'(f8), 32'd1);
    chk("halted at fault", 32'(h8), 32'd1);
    chk("req dropped at fault", 32'(req8), 32'd0);
    wait8(108);
    chk("fault held", 32'(f8), 32'd1);
    chk("output_data after abort", 32'(out8), 32'h06);
`else
    wait8(108);
    chk("still waiting req", 32'(req8), 32'd1);
    chk("still waiting addr", 32'(da8), 32'd0);
    chk("still waiting halted", 32'(h8), 32'd0);
    chk("fault tied low", 32'(f8), 32'd0);
    chk("output_data while waiting", 32'(out8), 32'h06);
`endif
    chk("scoreboard8 drained end", 32'(q8.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
